// File: rtl/digit_display_pkg.sv
// Shared types and helpers for the digit display Avalon-MM master.
package digit_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Data register offset inside each digit PIO slave
  localparam logic [31:0] PIO_DATA_OFFSET = 32'h0;

  // Widest BCD register supported: 8 digits plus one overflow nibble
  localparam int unsigned MAX_NIBBLES = 9;
  localparam int unsigned MAX_BCD_W   = 4 * MAX_NIBBLES;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [MAX_BCD_W-1:0] add3_nibbles(input logic [MAX_BCD_W-1:0] bcd);
    logic [MAX_BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < MAX_NIBBLES; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift per step, NUM_DIGITS+1 nibbles.
module bin2bcd_seq
  import digit_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        step,
  input  logic [BIN_W-1:0]            value,
  output logic                        finished,
  output logic [4*(NUM_DIGITS+1)-1:0] bcd,
  output logic                        overflow
);

  localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q, bin_nxt;
  logic [BCD_W-1:0] bcd_q, bcd_adj, bcd_nxt;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  // One conversion step: correct nibbles, then shift {bcd, bin} left by one
  always_comb begin
    bcd_adj            = BCD_W'(add3_nibbles(MAX_BCD_W'(bcd_q)));
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
  end

  // Shift registers, step counter and sticky carry out of the top nibble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      bin_q   <= value;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= CNT_W'(BIN_W);
    end else if (step && (cnt_q != '0)) begin
      bin_q   <= bin_nxt;
      bcd_q   <= bcd_nxt;
      carry_q <= carry_q | bcd_adj[BCD_W-1];
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  // finished flags that the final step is being applied this cycle
  assign finished = (cnt_q == CNT_W'(1));
  assign bcd      = bcd_q;
  assign overflow = carry_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/digit_display_master.sv
// Avalon-MM initiator: converts a binary value to BCD and writes one digit per PIO slave.
module digit_display_master
  import digit_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 3,
  parameter int unsigned BIN_W           = 10,
  parameter logic [31:0] DIGIT_BASE_ADDR = 32'h0,
  parameter logic [31:0] DIGIT_STRIDE    = 32'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [31:0]      avm_address,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic             avm_waitrequest
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);

  state_t           state_q, state_d;
  logic             load, step, accept;
  logic             finished, conv_ovf;
  logic [BCD_W-1:0] bcd;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic             ovf_q;
  logic [3:0]       digit;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .value    (value),
    .finished (finished),
    .bcd      (bcd),
    .overflow (conv_ovf)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (finished) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          accept = 1'b1;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Digit index and write address advance on each accepted write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else if (load) begin
      idx_q  <= '0;
      addr_q <= DIGIT_BASE_ADDR + PIO_DATA_OFFSET;
    end else if (accept) begin
      idx_q  <= idx_q + IDX_W'(1);
      addr_q <= addr_q + DIGIT_STRIDE;
    end
  end

  // Overflow is captured once conversion ends and held until the next accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (load) begin
      ovf_q <= 1'b0;
    end else if ((state_q == WRITE) && conv_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  // Current digit, saturated to 9 when the value does not fit
  always_comb begin
    digit = conv_ovf ? 4'd9 : bcd[{idx_q, 2'b00} +: 4];
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign overflow      = ovf_q;
  assign avm_write     = (state_q == WRITE);
  assign avm_address   = addr_q;
  assign avm_writedata = {28'd0, digit};

endmodule

// File: tb/tb_digit_display_master.sv
// Self-checking bench for digit_display_master with a behavioural digit/transfer model.
module tb_digit_display_master;

  localparam int unsigned N      = 3;
  localparam int unsigned BW     = 10;
  localparam logic [31:0] BASE   = 32'h0;
  localparam logic [31:0] STRIDE = 32'h10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BW-1:0] value;
  logic          busy, done, overflow;
  logic [31:0]   avm_address, avm_writedata;
  logic          avm_write;
  logic          avm_waitrequest;

  digit_display_master #(
    .NUM_DIGITS      (N),
    .BIN_W           (BW),
    .DIGIT_BASE_ADDR (BASE),
    .DIGIT_STRIDE    (STRIDE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .value           (value),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] a;
    logic [3:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] log_a[$];
  logic [3:0]  log_d[$];
  bit          m_busy     = 0;
  bit          m_ovf      = 0;
  int          m_first    = 0;
  int          m_done_cyc = -1;
  bit          ew, ed;

  // Expected writes for an accepted value: decimal digits LSD first, or all 9s when too big
  function automatic void model_accept(input int v);
    int lim, p;
    bit ov;
    lim = 1;
    for (int i = 0; i < N; i++) lim = lim * 10;
    lim = lim - 1;
    ov  = (v > lim);
    p   = 1;
    for (int i = 0; i < N; i++) begin
      wr_t w;
      w.a = BASE + 32'(i) * STRIDE;
      w.d = ov ? 4'd9 : 4'((v / p) % 10);
      exp_q.push_back(w);
      p = p * 10;
    end
    m_busy  = 1;
    m_ovf   = ov;
    m_first = cyc + BW + 1;
  endfunction

  // Compare outputs against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    if (reset) begin
      check("rst_avm_write", avm_write, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_address", avm_address, 0);
      check("rst_writedata", avm_writedata, 0);
      m_busy = 0;
      m_ovf = 0;
      m_done_cyc = -1;
      exp_q.delete();
    end else begin
      ew = m_busy && (cyc >= m_first) && (exp_q.size() > 0);
      ed = (cyc == m_done_cyc);
      check("avm_write", avm_write, ew);
      check("busy", busy, m_busy);
      check("done", done, ed);
      if (ew) begin
        check("avm_address", avm_address, exp_q[0].a);
        check("avm_writedata", avm_writedata, {28'd0, exp_q[0].d});
        if (!avm_waitrequest) begin
          log_a.push_back(avm_address);
          log_d.push_back(avm_writedata[3:0]);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done_cyc = cyc + 1;
        end
      end
      if (ed) begin
        check("overflow_at_done", overflow, m_ovf);
        m_busy = 0;
        m_done_cyc = -1;
      end else if (!m_busy) begin
        check("overflow_idle", overflow, m_ovf);
        if (start) model_accept(int'(value));
      end else if (cyc <= m_first) begin
        check("overflow_cleared", overflow, 0);
      end
    end
  end

  // ---------------- waitrequest driver ----------------
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'h0;
  bit          rand_wait  = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      avm_waitrequest = 1'b0;
      stall_left = 0;
    end else if (stall_left > 0 && avm_write && avm_address == stall_addr) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else if (rand_wait) begin
      avm_waitrequest = ($urandom_range(0, 2) == 0);
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int start_cyc;

  task automatic drive_start(input int v);
    @(posedge clk);
    #1;
    start = 1'b1;
    value = BW'(v);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Check three logged writes starting at log position base_i against literal digits
  task automatic check_log3(input string tag, input int base_i, input logic [3:0] d0,
                            input logic [3:0] d1, input logic [3:0] d2);
    check({tag, "_count"}, 32'(log_a.size()), 32'(base_i + 3));
    if (log_a.size() >= base_i + 3) begin
      check({tag, "_a0"}, log_a[base_i],     32'h00);
      check({tag, "_d0"}, 32'(log_d[base_i]),     32'(d0));
      check({tag, "_a1"}, log_a[base_i + 1], 32'h10);
      check({tag, "_d1"}, 32'(log_d[base_i + 1]), 32'(d1));
      check({tag, "_a2"}, log_a[base_i + 2], 32'h20);
      check({tag, "_d2"}, 32'(log_d[base_i + 2]), 32'(d2));
    end
  endtask

  int d_at, s0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    avm_waitrequest = 1'b0;
    idle(3);
    #1 reset = 1'b0;
    idle(2);

    // 1) 437 with no stalls
    log_a.delete(); log_d.delete();
    drive_start(437);
    s0 = start_cyc;
    wait_done(60, d_at);
    check("t1_latency", 32'(d_at - s0), 32'd14);
    check("t1_overflow", overflow, 0);
    check_log3("t1", 0, 4'd7, 4'd3, 4'd4);
    idle(2);

    // 2) 437 with three stall cycles on the 0x10 write
    log_a.delete(); log_d.delete();
    stall_addr = 32'h10;
    stall_left = 3;
    drive_start(437);
    s0 = start_cyc;
    wait_done(60, d_at);
    check("t2_latency", 32'(d_at - s0), 32'd17);
    check_log3("t2", 0, 4'd7, 4'd3, 4'd4);
    idle(2);

    // 3) 1023 saturates and overflow stays set
    log_a.delete(); log_d.delete();
    drive_start(1023);
    s0 = start_cyc;
    wait_done(60, d_at);
    check("t3_latency", 32'(d_at - s0), 32'd14);
    check("t3_overflow", overflow, 1);
    check_log3("t3", 0, 4'd9, 4'd9, 4'd9);
    idle(5);
    check("t3_overflow_sticky", overflow, 1);

    // 4) value 0, second start during conversion is ignored
    log_a.delete(); log_d.delete();
    drive_start(0);
    s0 = start_cyc;
    check("t4_overflow_cleared", overflow, 0);
    drive_start(555);
    wait_done(60, d_at);
    check("t4_latency", 32'(d_at - s0), 32'd14);
    check_log3("t4", 0, 4'd0, 4'd0, 4'd0);
    idle(2);

    // 5) reset while the 2nd write is stalled
    log_a.delete(); log_d.delete();
    stall_addr = 32'h10;
    stall_left = 1000;
    drive_start(437);
    d_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (avm_write && avm_address == 32'h10) begin
        d_at = cyc;
        break;
      end
    end
    check("t5_reached_2nd_write", 32'(d_at >= 0), 1);
    idle(1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("t5_write_drops_async", avm_write, 0);
    check("t5_busy_drops_async", busy, 0);
    idle(2);
    #1 reset = 1'b0;
    idle(30);
    #1 check("t5_idle_after_release", busy, 0);
    check("t5_one_write_only", 32'(log_a.size()), 1);

    // 6) back-to-back: start in the done cycle is ignored, start one cycle later accepted
    log_a.delete(); log_d.delete();
    drive_start(437);
    wait_done(60, d_at);
    start = 1'b1;
    value = BW'(77);
    @(posedge clk);
    #1 value = BW'(58);
    s0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, d_at);
    check("t6_latency", 32'(d_at - s0), 32'd14);
    check_log3("t6", 3, 4'd8, 4'd5, 4'd0);
    idle(2);

    // Boundary values and random traffic with random stalls
    rand_wait = 1;
    for (int i = 0; i < 30; i++) begin
      int v;
      case (i)
        0:       v = 999;
        1:       v = 1000;
        2:       v = 1;
        default: v = int'($urandom_range(0, 1023));
      endcase
      drive_start(v);
      if ($urandom_range(0, 1) == 1) begin
        idle(int'($urandom_range(0, 4)));
        drive_start(int'($urandom_range(0, 1023)));
      end
      wait_done(200, d_at);
      if (i == 0) check("b_999_overflow", overflow, 0);
      if (i == 1) check("b_1000_overflow", overflow, 1);
      idle(int'($urandom_range(0, 3)));
    end
    rand_wait = 0;
    idle(5);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
